// File: rtl/i2c_pkg.sv
// Shared types and constants for the mock I2C master and its bus target model.
package i2c_pkg;

    localparam int SCL_DIV = 4;
    localparam int PH_W    = $clog2(SCL_DIV);

    // Phases inside one SCL bit: low, low/data-change, high, high/sample
    localparam logic [PH_W-1:0] PH_CHG  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(2);
    localparam logic [PH_W-1:0] PH_SAMP = PH_W'(SCL_DIV - 1);

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP
    } i2c_state_e;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WR, S_RD, S_WAIT
    } slv_state_e;

endpackage

// File: rtl/i2c_slave.sv
// Clockless single-byte I2C target: ACKs its own address, stores written bytes,
// returns the stored byte on reads. Several instances may share one bus.
module i2c_slave
    import i2c_pkg::*;
(
    inout  wire        sda,
    input  logic       scl,
    input  logic [6:0] address,
    output logic [7:0] data
);

    slv_state_e st     = S_IDLE;
    logic       oe     = 1'b0;
    logic [7:0] data_q = 8'h00;
    logic [3:0] bitcnt;
    logic [7:0] sh, dout;
    logic       rw, hit, scl_q, sda_q;
    logic       sda_in;
    logic [7:0] rx_byte;

    assign sda     = oe ? 1'b0 : 1'bz;
    assign sda_in  = sda;
    assign rx_byte = {sh[6:0], sda_in};
    assign data    = data_q;

    // Edge-driven bus model: previous levels of scl/sda tell which edge fired
    always @(posedge scl or negedge scl or posedge sda_in or negedge sda_in) begin
        scl_q <= scl;
        sda_q <= sda_in;
        if (scl && scl_q && sda_q && !sda_in) begin
            st     <= S_ADDR;
            bitcnt <= 4'd0;
            oe     <= 1'b0;
        end else if (scl && scl_q && !sda_q && sda_in) begin
            st <= S_IDLE;
            oe <= 1'b0;
        end else if (scl && !scl_q) begin
            if (st inside {S_ADDR, S_WR, S_RD}) begin
                if (bitcnt < 4'd8) sh <= rx_byte;
                if (bitcnt == 4'd7 && st == S_ADDR) begin
                    hit <= (rx_byte[7:1] == address);
                    rw  <= rx_byte[0];
                end
                if (bitcnt == 4'd7 && st == S_WR) data_q <= rx_byte;
                if (bitcnt < 4'd9) bitcnt <= bitcnt + 4'd1;
            end
        end else if (!scl && scl_q) begin
            case (st)
                S_ADDR: begin
                    if (bitcnt == 4'd8) begin
                        if (hit) oe <= 1'b1;
                        else     st <= S_WAIT;
                    end else if (bitcnt == 4'd9) begin
                        bitcnt <= 4'd0;
                        if (rw == RW_READ) begin
                            st   <= S_RD;
                            oe   <= ~data_q[7];
                            dout <= {data_q[6:0], 1'b0};
                        end else begin
                            st <= S_WR;
                            oe <= 1'b0;
                        end
                    end
                end
                S_WR: begin
                    if (bitcnt == 4'd8) oe <= 1'b1;
                    else if (bitcnt == 4'd9) begin
                        oe <= 1'b0;
                        st <= S_WAIT;
                    end
                end
                S_RD: begin
                    if (bitcnt == 4'd8) oe <= 1'b0;
                    else if (bitcnt == 4'd9) st <= S_WAIT;
                    else if (bitcnt != 4'd0) begin
                        oe   <= ~dout[7];
                        dout <= {dout[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/i2c_mock_master.sv
// Single-byte I2C master, 4 clocks per SCL bit. Define I2C_MASTER_TRACE_EN to
// print each transaction at STOP in simulation.
module i2c_mock_master
    import i2c_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       write,
    input  logic [7:0] write_data,
    input  logic [6:0] address,
    output logic [7:0] read_data,
    output logic       ready,
    output logic       error,
    inout  wire        sda,
    output logic       scl
);

    i2c_state_e      state;
    logic [PH_W-1:0] ph;
    logic [2:0]      bit_idx;
    logic [7:0]      frame_q, wdata_q, shreg, rdata_q;
    logic            sda_oe, scl_q, ready_q, error_q;
    logic            sda_in;

    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign sda_in    = sda;
    assign scl       = scl_q;
    assign ready     = ready_q;
    assign error     = error_q;
    assign read_data = rdata_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            ph      <= '0;
            bit_idx <= '0;
            frame_q <= '0;
            wdata_q <= '0;
            shreg   <= '0;
            rdata_q <= 8'h00;
            sda_oe  <= 1'b0;
            scl_q   <= 1'b1;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            ph    <= ph + PH_W'(1);
            scl_q <= (ph >= PH_HIGH);
            case (state)
                IDLE: begin
                    ph     <= '0;
                    scl_q  <= 1'b1;
                    sda_oe <= 1'b0;
                    if (ready_q && start) begin
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                        frame_q <= {address, write ? RW_WRITE : RW_READ};
                        wdata_q <= write_data;
                        state   <= START;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    scl_q <= 1'b1;
                    if (ph == PH_HIGH) sda_oe <= 1'b1;
                    if (ph == PH_SAMP) begin
                        bit_idx <= '0;
                        state   <= ADDR;
                    end
                end
                ADDR, WDATA: begin
                    if (ph == PH_CHG)
                        sda_oe <= (state == ADDR) ? ~frame_q[~bit_idx] : ~wdata_q[~bit_idx];
                    if (ph == PH_SAMP) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= (state == ADDR) ? ADDR_ACK : WACK;
                    end
                end
                ADDR_ACK, WACK: begin
                    if (ph == PH_CHG) sda_oe <= 1'b0;
                    if (ph == PH_SAMP) begin
                        bit_idx <= '0;
                        // A released line here means nobody answered
                        if (sda_in) begin
                            error_q <= 1'b1;
                            state   <= STOP;
                        end else if (state == WACK)         state <= STOP;
                        else if (frame_q[0] == RW_WRITE)    state <= WDATA;
                        else                                state <= RDATA;
                    end
                end
                RDATA: begin
                    if (ph == PH_CHG) sda_oe <= 1'b0;
                    if (ph == PH_SAMP) begin
                        shreg   <= {shreg[6:0], sda_in};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RNACK;
                    end
                end
                RNACK: begin
                    sda_oe <= 1'b0;
                    if (ph == PH_SAMP) begin
                        rdata_q <= shreg;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (ph == PH_CHG) sda_oe <= 1'b1;
                    if (ph == PH_SAMP) begin
                        sda_oe <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef I2C_MASTER_TRACE_EN
    always_ff @(posedge clock) begin
        if (reset && state == STOP && ph == PH_SAMP)
            $display("i2c_mock_master: addr=0x%02h %s data=0x%02h %s",
                     frame_q[7:1], (frame_q[0] == RW_READ) ? "read" : "write",
                     (frame_q[0] == RW_READ) ? rdata_q : wdata_q,
                     error_q ? "nack" : "ack");
    end
`endif

endmodule

// File: tb/tb_i2c_mock_master.sv
// Bench: master plus four targets at 0x50..0x53 on one pulled-up bus.
module tb_i2c_mock_master;
    import i2c_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       write = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic [6:0] address = 7'h00;
    wire  [7:0] read_data;
    wire        ready, error, scl;
    wire        sda;
    wire  [3:0][7:0] slv_data;

    pullup (sda);

    i2c_mock_master dut (
        .clock(clock), .reset(reset), .start(start), .write(write),
        .write_data(write_data), .address(address), .read_data(read_data),
        .ready(ready), .error(error), .sda(sda), .scl(scl)
    );

    for (genvar g = 0; g < 4; g++) begin : g_slv
        i2c_slave u_slv (.sda(sda), .scl(scl), .address(7'(80 + g)), .data(slv_data[g]));
    end

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a byte store per existing target, nothing else
    logic [7:0] m_mem [80:83];
    logic       m_err;
    logic [7:0] m_rd;

    typedef struct {
        logic       w;
        logic [6:0] a;
        logic [7:0] d;
        bit         poke;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model(input logic w, input logic [6:0] a, input logic [7:0] d);
        if (a >= 7'd80 && a <= 7'd83) begin
            m_err = 1'b0;
            if (w) m_mem[a] = d;
            else   m_rd = m_mem[a];
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_slaves(input string tag);
        for (int g = 0; g < 4; g++)
            check($sformatf("%s slave%0d data", tag, 80 + g), slv_data[g], m_mem[80 + g]);
    endtask

    // Issue one transaction from a negedge and pad to a 100-clock window
    task automatic run_txn(input logic w, input logic [6:0] a, input logic [7:0] d, input bit poke);
        int lat;
        lat = 0;
        while (ready !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        write = w; address = a; write_data = d; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ready drops after start", ready, 0);
        check("error cleared after start", error, 0);
        address = 7'($urandom); write = 1'($urandom); write_data = 8'($urandom);
        lat = 0;
        while (ready !== 1'b1 && lat < 95) begin
            @(negedge clock);
            lat++;
            start = poke && (lat == 20);
            if (start) begin
                address = 7'd82; write = 1'b1; write_data = 8'hEE;
            end
        end
        start = 1'b0;
        check($sformatf("ready within 90 clocks (took %0d)", lat), (lat <= 90), 1);
        if (lat < 98) repeat (98 - lat) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 80; i <= 83; i++) m_mem[i] = 8'h00;
        m_err = 1'b0;
        m_rd  = 8'h00;

        vecs[0] = '{1'b1, 7'd80, 8'h21, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 7'd81, 8'h56, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 7'd82, 8'h18, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 7'd83, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 7'd80, 8'h00, 1'b0, 1'b0, 8'h21};
        vecs[5] = '{1'b1, 7'h10, 8'h77, 1'b0, 1'b1, 8'h21};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset ready", ready, 1);
        check("reset error", error, 0);
        check("reset read_data", read_data, 8'h00);
        check("reset scl", scl, 1);
        check("reset sda", sda, 1);
        check_slaves("power-up");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].poke);
            model(vecs[i].w, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d error", i), error, vecs[i].exp_err);
            check($sformatf("vec%0d read_data", i), read_data, vecs[i].exp_rd);
            check_slaves($sformatf("vec%0d", i));
        end

        // Reset while the target at 80 is mid-byte in a read (bit 5 of 0x21 on the bus)
        @(negedge clock);
        write = 1'b0; address = 7'd80; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (51) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mid-read reset ready", ready, 1);
        check("mid-read reset scl", scl, 1);
        check("mid-read reset sda", sda, 1);
        check("mid-read reset error", error, 0);
        check("mid-read reset read_data", read_data, 8'h00);
        m_rd = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        run_txn(1'b1, 7'd81, 8'h86, 1'b0);
        model(1'b1, 7'd81, 8'h86);
        check("post-reset write error", error, 0);
        check_slaves("post-reset");

        for (int i = 0; i < 16; i++) begin
            logic       w;
            logic [6:0] a;
            logic [7:0] d;
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(78 + $urandom_range(0, 7));
            d = 8'($urandom);
            run_txn(w, a, d, (i == 5));
            model(w, a, d);
            check($sformatf("rnd%0d error", i), error, m_err);
            check($sformatf("rnd%0d read_data", i), read_data, m_rd);
            check_slaves($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
